cpu_dmem_responder: RTL

- Responder for the CPU data-memory port. Drives in_m and stall back to the CPU, and sits between the CPU and a variable-latency 16-bit external memory (req/ack).
- Writes are posted into a small write buffer. A read that misses the buffer stalls the CPU until the read data has been fetched.
- Instantiated next to the CPU in the top level. The top level drives CPU resetN = !reset.

---
 rtl/cpu_dmem_pkg.sv | 18 +
 rtl/cpu_wbuf.sv | 73 +++++++
 rtl/cpu_dmem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_dmem_pkg.sv
// rtl/cpu_dmem_pkg.sv - shared types for the CPU data-memory responder
package cpu_dmem_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cpu_wbuf.sv
// rtl/cpu_wbuf.sv - posted-write FIFO with youngest-match read forwarding
module cpu_wbuf #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]  count;
    logic [IDX_W-1:0]  slot;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                         (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head_addr_o = addr_mem[rd_ptr_q[IDX_W-1:0]];
    assign head_data_o = data_mem[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && !full_o) begin
            addr_mem[wr_ptr_q[IDX_W-1:0]] <= push_addr_i;
            data_mem[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest write.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q[IDX_W-1:0] + IDX_W'(i);
            if ((PTR_W'(i) < count) && (addr_mem[slot] == lookup_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_mem[slot];
            end
        end
    end

endmodule

// File: rtl/cpu_dmem_responder.sv
// rtl/cpu_dmem_responder.sv - CPU data port responder with posted writes and stalling reads
module cpu_dmem_responder
    import cpu_dmem_pkg::*;
#(
    parameter int WB_DEPTH = 2,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              read_m,
    input  logic              write_m,
    input  logic [DATA_W-1:0] out_m,
    output logic [DATA_W-1:0] in_m,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              wb_full, wb_empty, fwd_hit;
    logic [DATA_W-1:0] fwd_data, head_data;
    logic [ADDR_W-1:0] head_addr;
    logic              rd_hit, hit, stall_int, push, pop;

    cpu_wbuf #(
        .DEPTH  (WB_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk_i         (clk),
        .rst_i         (reset),
        .push_i        (push),
        .push_addr_i   (data_addr),
        .push_data_i   (out_m),
        .pop_i         (pop),
        .lookup_addr_i (data_addr),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .full_o        (wb_full),
        .empty_o       (wb_empty),
        .fwd_hit_o     (fwd_hit),
        .fwd_data_o    (fwd_data)
    );

    // stall must stay independent of write_m/out_m: the CPU gates write_m with it.
    assign rd_hit    = rd_valid_q && (rd_addr_q == data_addr);
    assign hit       = fwd_hit || rd_hit;
    assign stall_int = wb_full || (read_m && !hit);
    assign stall     = !reset && stall_int;
    assign in_m      = reset ? '0 : (fwd_hit ? fwd_data : rd_data_q);
    assign push      = write_m && !reset && !wb_full;
    assign pop       = (state_q == WR) && mem_ack;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        rd_valid_d  = rd_valid_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (read_m && rd_hit && !stall_int) begin
            rd_valid_d = 1'b0;
        end
        if (push && rd_valid_q && (rd_addr_q == data_addr)) begin
            rd_data_d = out_m;
        end

        case (state_q)
            IDLE: begin
                if (!wb_empty) begin
                    state_d     = WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                end else if (read_m && !hit) begin
                    state_d    = RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = data_addr;
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    rd_valid_d = 1'b1;
                    rd_addr_d  = mem_addr_q;
                    rd_data_d  = mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
